btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports BTNC, BTNU, BTND, BTNL, BTNR, input, 1 each, raw asynchronous push-button levels.
REQ-005 SHALL have port btn_db, output, 5, debounced button levels, index [0]=C [1]=U [2]=D [3]=L [4]=R.
REQ-006 SHALL have port btn_press, output, 5, single-cycle press pulses, same indexing.
REQ-007 SHALL have port op_sel, output, 5, one-hot latched operation select, same indexing; all zero means none selected.
REQ-008 SHALL have port op_sel_vld, output, 1, high when op_sel is non-zero.

Function
REQ-009 SHALL pass each raw button through a 2-flop synchronizer before any other logic.
REQ-010 SHALL keep one debounce counter per button, ceil(log2(DEBOUNCE_CYCLES)) bits wide, and one stable level per button.
REQ-011 SHALL clear a button's counter on any cycle its synchronized level equals its stable level.
REQ-012 SHALL increment a button's counter on each cycle its synchronized level differs from its stable level.
REQ-013 SHALL toggle the stable level and clear the counter at the edge where the levels differ and the counter equals DEBOUNCE_CYCLES-1.
REQ-014 SHALL drive btn_db directly from the stable levels.
REQ-015 SHALL raise btn_db at edge N+1+DEBOUNCE_CYCLES, where N is the first edge sampling raw=1 and raw stays 1 throughout; release timing SHALL be symmetric.
REQ-016 SHALL reject, with no output change, any raw excursion shorter than DEBOUNCE_CYCLES synchronized cycles.
REQ-017 SHALL assert btn_press[i] for exactly the first cycle in which btn_db[i] reads 1.
REQ-018 SHALL generate no pulse on release.
REQ-019 SHALL load op_sel at the edge after any btn_press bit is high, with the one-hot of the highest-priority pressed button.
REQ-020 SHALL use press priority C > U > D > L > R, matching the downstream operation-select priority.
REQ-021 SHALL hold op_sel when no press pulse is present, including across releases.
REQ-022 SHALL keep op_sel one-hot or zero at all times.
REQ-023 SHALL treat buttons independently, so simultaneous bounces on several inputs debounce in parallel.

Reset
REQ-024 SHALL, while rst is high at an edge, set synchronizer flops, stable levels, counters, the press-history register, btn_db, btn_press and op_sel to 0, and op_sel_vld to 0.
REQ-025 SHALL, when rst falls with a button still held, re-qualify that button with the full REQ-015 latency, measured from the first post-reset edge.
REQ-026 SHALL NOT let reset asserted mid-count leave any partial count or pulse behind.

Structure
REQ-027 SHALL place in a shared package btn_pkg: button index constants (BTN_C=0 .. BTN_R=4), NUM_BTNS=5, and the priority order.
REQ-028 SHALL implement one natural sub-module, btn_debounce (synchronizer, counter, stable level, press pulse), instantiated NUM_BTNS times.
REQ-029 SHALL implement the priority encoder and op_sel register in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 SHALL cover clean press: BTNU=1 from edge 0, held 20 cycles -> btn_db[1] rises at edge 5, btn_press=00010 for 1 cycle, op_sel=00010 from edge 6, op_sel_vld=1.
REQ-031 SHALL cover bounce: BTNL raw 1,0,1,0 (2 cycles each) then steady 1 -> no pulse during bounce, exactly one btn_press[3] 5 edges after the final rise is sampled, op_sel=01000.
REQ-032 SHALL cover simultaneous press: BTNL and BTNC rise on the same edge -> both pulses in the same cycle, op_sel=00001.
REQ-033 SHALL cover glitch and release: BTNR high for 3 cycles -> no btn_db, no pulse; then releasing a held button -> btn_db falls after 5 edges, no pulse, op_sel unchanged.
REQ-034 SHALL cover mid-count reset: BTND held, rst pulsed at edge 3 -> all outputs 0; btn_db[2] rises 5 edges after the first post-reset edge.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared button definitions: index map, button count and the press priority
// used to pick the latched operation.
package btn_pkg;

    typedef enum logic [2:0] {
        BTN_C = 3'd0,
        BTN_U = 3'd1,
        BTN_D = 3'd2,
        BTN_L = 3'd3,
        BTN_R = 3'd4
    } btn_idx_e;

    localparam int unsigned NUM_BTNS = 5;

    // Priority order C > U > D > L > R; matches downstream operation decode.
    function automatic logic [NUM_BTNS-1:0] prio_onehot(input logic [NUM_BTNS-1:0] press);
        logic [NUM_BTNS-1:0] sel;
        sel = '0;
        if (press[BTN_C])      sel[BTN_C] = 1'b1;
        else if (press[BTN_U]) sel[BTN_U] = 1'b1;
        else if (press[BTN_D]) sel[BTN_D] = 1'b1;
        else if (press[BTN_L]) sel[BTN_L] = 1'b1;
        else if (press[BTN_R]) sel[BTN_R] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, debounced
// level and a single-cycle press pulse on the rising debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // High only in the first cycle the debounced level reads 1; never on release.
    assign press = level & ~level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Five-button front end: per-button debounce plus a latched one-hot
// operation select chosen by press priority.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                BTNC,
    input  logic                BTNU,
    input  logic                BTND,
    input  logic                BTNL,
    input  logic                BTNR,
    output logic [NUM_BTNS-1:0] btn_db,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] op_sel,
    output logic                op_sel_vld
);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] sel_next;

    assign raw = {BTNR, BTNL, BTND, BTNU, BTNC};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(btn_db[i]),
            .press(btn_press[i])
        );
    end

    assign sel_next = prio_onehot(btn_press);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_sel     <= '0;
            op_sel_vld <= 1'b0;
        end else if (|btn_press) begin
            op_sel     <= sel_next;
            op_sel_vld <= |sel_next;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BTNC = 1'b0, BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
    logic [4:0] btn_db, btn_press, op_sel;
    logic       op_sel_vld;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .BTNC      (BTNC),
        .BTNU      (BTNU),
        .BTND      (BTND),
        .BTNL      (BTNL),
        .BTNR      (BTNR),
        .btn_db    (btn_db),
        .btn_press (btn_press),
        .op_sel    (op_sel),
        .op_sel_vld(op_sel_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] db, input logic [4:0] pr,
                             input logic [4:0] sel, input logic vld);
        check({tag, ".db"}, btn_db, db);
        check({tag, ".press"}, btn_press, pr);
        check({tag, ".op_sel"}, op_sel, sel);
        check({tag, ".vld"}, {4'b0, op_sel_vld}, {4'b0, vld});
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_all("reset", 5'b00000, 5'b00000, 5'b00000, 1'b0);
        rst = 1'b0;
        tick();

        // Clean press on U: raw first sampled at edge 0, db rises at edge 5
        BTNU = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            check("clean.pre_db", btn_db, 5'b00000);
            check("clean.pre_press", btn_press, 5'b00000);
        end
        tick();
        check_all("clean.e5", 5'b00010, 5'b00010, 5'b00000, 1'b0);
        tick();
        check_all("clean.e6", 5'b00010, 5'b00000, 5'b00010, 1'b1);
        repeat (5) tick();
        check_all("clean.hold", 5'b00010, 5'b00000, 5'b00010, 1'b1);

        // Bounce on L: 1,0,1,0 for two cycles each, then steady 1
        for (int b = 0; b < 4; b++) begin
            BTNL = (b % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) begin
                tick();
                check("bounce.db", btn_db, 5'b00010);
                check("bounce.press", btn_press, 5'b00000);
            end
        end
        BTNL = 1'b1;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("bounce.settle_press", btn_press, 5'b00000);
        end
        check("bounce.settle_db", btn_db, 5'b00010);
        tick();
        check_all("bounce.e5", 5'b01010, 5'b01000, 5'b00010, 1'b1);
        tick();
        check_all("bounce.e6", 5'b01010, 5'b00000, 5'b01000, 1'b1);

        // Release L: no pulse, op_sel held
        BTNL = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            check("relL.press", btn_press, 5'b00000);
        end
        check_all("relL.done", 5'b00010, 5'b00000, 5'b01000, 1'b1);

        // Simultaneous L and C: C wins priority
        BTNL = 1'b1;
        BTNC = 1'b1;
        repeat (5) tick();
        check("simul.e4_press", btn_press, 5'b00000);
        tick();
        check_all("simul.e5", 5'b01011, 5'b01001, 5'b01000, 1'b1);
        tick();
        check_all("simul.e6", 5'b01011, 5'b00000, 5'b00001, 1'b1);
        BTNL = 1'b0;
        BTNC = 1'b0;
        repeat (8) tick();
        check_all("simul.rel", 5'b00010, 5'b00000, 5'b00001, 1'b1);

        // Glitch on R: three cycles high is one short of acceptance
        BTNR = 1'b1;
        repeat (3) tick();
        BTNR = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("glitch.db", btn_db, 5'b00010);
            check("glitch.press", btn_press, 5'b00000);
        end

        // Release held U: db falls 5 edges later, no pulse, op_sel unchanged
        BTNU = 1'b0;
        repeat (5) tick();
        check_all("relU.e4", 5'b00010, 5'b00000, 5'b00001, 1'b1);
        tick();
        check_all("relU.e5", 5'b00000, 5'b00000, 5'b00001, 1'b1);
        tick();
        check_all("relU.e6", 5'b00000, 5'b00000, 5'b00001, 1'b1);

        // Mid-count reset with D held, then full re-qualification
        BTND = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_all("midrst.rst", 5'b00000, 5'b00000, 5'b00000, 1'b0);
        rst = 1'b0;
        for (int e = 0; e <= 4; e++) begin
            tick();
            check("midrst.pre_db", btn_db, 5'b00000);
            check("midrst.pre_press", btn_press, 5'b00000);
        end
        tick();
        check_all("midrst.e5", 5'b00100, 5'b00100, 5'b00000, 1'b0);
        tick();
        check_all("midrst.e6", 5'b00100, 5'b00000, 5'b00100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
